// File: rtl/serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : serial_add_ctrl
// Description : Bit-serial add/subtract unit. One full-adder cell is reused
//               LSB first, one bit per RUN cycle, behind an IDLE/RUN/DONE FSM.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op_sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int                 c_CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_next;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]   r_sum;
    logic               r_carry;
    logic               r_cout;
    logic               r_ovf;
    logic [c_CNT_W-1:0] r_cnt;
    logic               w_accept;
    logic               w_last;
    logic               w_s;
    logic               w_c;
    logic [WIDTH-1:0]   w_acc_next;

    assign w_accept = start && (r_state == c_IDLE);
    assign w_last   = (r_cnt == c_LAST);

    // Single full-adder cell operating on the current LSBs of the shift registers
    assign w_s = r_a[0] ^ r_b[0] ^ r_carry;
    assign w_c = (r_a[0] & r_b[0]) | (r_carry & (r_a[0] ^ r_b[0]));

    always_comb begin
        w_acc_next        = r_acc;
        w_acc_next[r_cnt] = w_s;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        ready        = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            c_IDLE: begin
                ready = 1'b1;
                if (w_accept) begin
                    w_state_next = c_RUN;
                end
            end
            c_RUN: begin
                busy = 1'b1;
                if (w_last) begin
                    w_state_next = c_DONE;
                end
            end
            c_DONE: begin
                done         = 1'b1;
                w_state_next = c_IDLE;
            end
            default: begin
                w_state_next = c_IDLE;
            end
        endcase
    end

    // Partial bits collect in r_acc; the visible result only moves on the final bit
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_cnt   <= '0;
        end else if (w_accept) begin
            r_a     <= a;
            r_b     <= op_sub ? ~b : b;
            r_carry <= op_sub ? 1'b1 : cin;
            r_acc   <= '0;
            r_cnt   <= '0;
        end else if (r_state == c_RUN) begin
            r_a     <= r_a >> 1;
            r_b     <= r_b >> 1;
            r_carry <= w_c;
            r_acc   <= w_acc_next;
            r_cnt   <= r_cnt + c_CNT_W'(1);
            if (w_last) begin
                r_sum  <= w_acc_next;
                r_cout <= w_c;
                r_ovf  <= r_carry ^ w_c;
            end
        end
    end

    assign sum  = r_sum;
    assign cout = r_cout;
    assign ovf  = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_add_ctrl
// Description : Scoreboard bench for serial_add_ctrl (WIDTH=8), directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_add_ctrl;

    typedef struct packed {
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
    } res_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       op_sub;
    logic       cin;
    logic [7:0] a;
    logic [7:0] b;
    logic       ready;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;

    res_t exp_q[$];
    res_t mon_e;
    int   done_cyc[$];
    int   checks   = 0;
    int   failures = 0;
    int   n_done   = 0;
    int   cyc      = 0;

    serial_add_ctrl #(.WIDTH(8)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op_sub (op_sub),
        .a      (a),
        .b      (b),
        .cin    (cin),
        .ready  (ready),
        .busy   (busy),
        .done   (done),
        .sum    (sum),
        .cout   (cout),
        .ovf    (ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Monitor: every done pulse is matched against the oldest pending expectation
    always @(negedge clk) begin
        if (done) begin
            n_done++;
            done_cyc.push_back(cyc);
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_done: done=1 at cycle %0d with no operation pending (sum=0x%02h)", cyc, sum);
            end else begin
                mon_e = exp_q.pop_front();
                if ({sum, cout, ovf} !== mon_e) begin
                    failures++;
                    $display("FAIL result: got sum=0x%02h cout=%0b ovf=%0b, expected sum=0x%02h cout=%0b ovf=%0b",
                             sum, cout, ovf, mon_e.sum, mon_e.cout, mon_e.ovf);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic issue(input logic sub, input logic [7:0] ia, input logic [7:0] ib, input logic ic,
                         input logic [7:0] es, input logic ec, input logic eo, input bit push);
        int t;
        t = 0;
        @(negedge clk);
        while (!ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!ready) begin
            checks++;
            failures++;
            $display("FAIL issue_timeout: ready=%0b expected 1", ready);
            return;
        end
        op_sub = sub;
        a      = ia;
        b      = ib;
        cin    = ic;
        start  = 1'b1;
        if (push) exp_q.push_back({es, ec, eo});
        @(posedge clk);
        #1;
        start  = 1'b0;
        op_sub = 1'($urandom);
        a      = 8'($urandom);
        b      = 8'($urandom);
        cin    = 1'($urandom);
    endtask

    task automatic wait_done(input int target);
        int t;
        t = 0;
        while (n_done < target && t < 40) begin
            @(posedge clk);
            t++;
        end
        chk("done_count", 32'(n_done), 32'(target));
    endtask

    initial begin
        int  exp_done;
        int  accepts;
        int  nd;
        int  base_done;
        bit  saw_busy;

        rst = 1'b1; start = 1'b0; op_sub = 1'b0; cin = 1'b0; a = '0; b = '0;
        exp_done = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_state", 32'({ready, busy, done, sum, cout, ovf}), 32'({1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0}));

        // Latency profile of one add
        issue(1'b0, 8'h01, 8'h00, 1'b0, 8'h01, 1'b0, 1'b0, 1'b1);
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            chk($sformatf("timing_k+%0d", i), 32'({busy, done, ready}),
                (i <= 8) ? 32'h4 : ((i == 9) ? 32'h2 : 32'h1));
        end
        exp_done++;
        wait_done(exp_done);

        issue(1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1); exp_done++; wait_done(exp_done);
        issue(1'b0, 8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1, 1'b1); exp_done++; wait_done(exp_done);
        issue(1'b1, 8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b1); exp_done++; wait_done(exp_done);
        issue(1'b1, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1, 1'b1); exp_done++; wait_done(exp_done);
        issue(1'b0, 8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1); exp_done++; wait_done(exp_done);

        // Stray starts during RUN and DONE must be dropped
        issue(1'b0, 8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        @(negedge clk);
        start = 1'b1; a = 8'hFF; b = 8'hFF; op_sub = 1'b0;
        @(posedge clk);
        #1 start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) break;
        end
        start = 1'b1; a = 8'hFF; b = 8'hFF;
        @(posedge clk);
        #1 start = 1'b0;
        saw_busy = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (busy) saw_busy = 1'b1;
        end
        chk("no_queued_op", 32'(saw_busy), 32'h0);
        exp_done++;
        chk("single_done", 32'(n_done), 32'(exp_done));

        // Reset wins over start in the same cycle
        @(negedge clk);
        rst = 1'b1; start = 1'b1; a = 8'h01; b = 8'h01;
        @(posedge clk);
        #1 rst = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("rst_over_start", 32'({ready, busy}), 32'h2);

        // Reset in the 4th RUN cycle aborts the operation
        issue(1'b0, 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        chk("in_run_before_rst", 32'(busy), 32'h1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("abort_idle", 32'({ready, busy}), 32'h2);
        base_done = n_done;
        repeat (12) @(negedge clk);
        chk("abort_no_done", 32'(n_done), 32'(base_done));
        chk("abort_outputs", 32'({sum, cout, ovf}), 32'h0);

        // start held high for 30 cycles
        accepts = 0;
        @(negedge clk);
        op_sub = 1'b0; cin = 1'b0; a = 8'h02; b = 8'h03; start = 1'b1;
        for (int i = 0; i < 30; i++) begin
            if (ready) begin
                exp_q.push_back({8'h05, 1'b0, 1'b0});
                accepts++;
            end
            @(negedge clk);
        end
        start = 1'b0;
        chk("stream_accepts", 32'(accepts), 32'h3);
        exp_done += 3;
        wait_done(exp_done);
        nd = done_cyc.size();
        if (nd >= 3) begin
            chk("stream_gap1", 32'(done_cyc[nd-2] - done_cyc[nd-3]), 32'd10);
            chk("stream_gap2", 32'(done_cyc[nd-1] - done_cyc[nd-2]), 32'd10);
        end else begin
            chk("stream_done_pulses", 32'(nd), 32'h3);
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
